// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared state encoding and widths for the I2C command arbiter
package i2c_arb_pkg;
   localparam int I2C_WORD_W = 24;
   localparam int GAP_CNT_W  = 8;
   localparam int TO_CNT_W   = 16;
   localparam int RETRY_W    = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_GAP     = 3'd3,
      ST_RELEASE = 3'd4
   } arbState_t;
endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// rtl/i2c_cmd_arbiter_rr_pick.sv - combinational round-robin select: first request at or after start
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [N_REQ-1:0] gnt,
   output logic             valid
);
   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, start} + SUM_W'(i);
         if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
         idx = sum[IDX_W-1:0];
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin sharing of one I2C controller with NACK retry.
// Define I2C_ARB_TIMEOUT_EN to add the WAIT-state watchdog and TIMEOUT_CYC parameter.
module i2c_cmd_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_RETRY = 3,
   parameter int GAP_CYC   = 8
`ifdef I2C_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 65535
`endif
) (
   input  logic                        iCLK,
   input  logic                        iRST,
   input  logic [N_REQ-1:0]            iREQ,
   input  logic [I2C_WORD_W*N_REQ-1:0] iREQ_DATA,
   output logic [N_REQ-1:0]            oGNT,
   output logic [N_REQ-1:0]            oDONE,
   output logic [N_REQ-1:0]            oERR,
   output logic                        oBUSY,
   output logic                        oTIMEOUT,
   output logic [I2C_WORD_W-1:0]       oI2C_DATA,
   output logic                        oI2C_GO,
   input  logic                        iI2C_END,
   input  logic                        iI2C_ACK
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYC - 1);

   arbState_t             state, stateNext;
   logic [N_REQ-1:0]      gntNext, doneNext, errNext;
   logic                  goNext;
   logic [I2C_WORD_W-1:0] dataNext, pickData;
   logic [RETRY_W-1:0]    retry, retryNext;
   logic [GAP_CNT_W-1:0]  gapCnt, gapNext;
   logic [IDX_W-1:0]      rrPtr, ptrNext, relPtr;
   logic                  armed, armedNext;
   logic [N_REQ-1:0]      pickGnt;
   logic                  pickValid;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [TO_CNT_W-1:0]   toCnt, toCntNext;
   logic                  toFlag, toFlagNext;
   assign oTIMEOUT = toFlag;
`else
   assign oTIMEOUT = 1'b0;
`endif

   assign oBUSY = (state != ST_IDLE);

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) uPick (
      .req   (iREQ),
      .start (rrPtr),
      .gnt   (pickGnt),
      .valid (pickValid)
   );

   // Slice of the winning requester, and the search start following the current grant.
   always_comb begin
      pickData = '0;
      relPtr   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pickGnt[k]) pickData = iREQ_DATA[I2C_WORD_W*k +: I2C_WORD_W];
         if (oGNT[k])    relPtr   = IDX_W'((k + 1) % N_REQ);
      end
   end

   always_comb begin
      stateNext = state;
      gntNext   = oGNT;
      doneNext  = '0;
      errNext   = '0;
      goNext    = oI2C_GO;
      dataNext  = oI2C_DATA;
      retryNext = retry;
      gapNext   = gapCnt;
      ptrNext   = rrPtr;
      armedNext = armed;
`ifdef I2C_ARB_TIMEOUT_EN
      toCntNext  = toCnt;
      toFlagNext = toFlag;
`endif
      case (state)
         ST_IDLE: begin
            if (pickValid) begin
               dataNext  = pickData;
               gntNext   = pickGnt;
               retryNext = '0;
               stateNext = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            goNext    = 1'b1;
            armedNext = 1'b0;
            stateNext = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            toCntNext = '0;
`endif
         end
         ST_WAIT: begin
            // A stale END from the previous attempt is ignored for the first WAIT cycle.
            armedNext = 1'b1;
            if (armed && iI2C_END) begin
               goNext  = 1'b0;
               gapNext = '0;
               if (!iI2C_ACK) begin
                  doneNext  = oGNT;
                  gntNext   = '0;
                  ptrNext   = relPtr;
                  stateNext = ST_RELEASE;
               end else if (retry < RETRY_W'(MAX_RETRY)) begin
                  retryNext = retry + 1'b1;
                  stateNext = ST_GAP;
               end else begin
                  errNext   = oGNT;
                  gntNext   = '0;
                  ptrNext   = relPtr;
                  stateNext = ST_RELEASE;
               end
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (toCnt == TO_CNT_W'(TIMEOUT_CYC - 1)) begin
               goNext     = 1'b0;
               gapNext    = '0;
               errNext    = oGNT;
               gntNext    = '0;
               ptrNext    = relPtr;
               toFlagNext = 1'b1;
               stateNext  = ST_RELEASE;
            end else begin
               toCntNext = toCnt + 1'b1;
            end
`endif
         end
         ST_GAP: begin
            if (gapCnt == GAP_LAST) stateNext = ST_ISSUE;
            else                    gapNext   = gapCnt + 1'b1;
         end
         ST_RELEASE: begin
            if (gapCnt == GAP_LAST) begin
               stateNext = ST_IDLE;
               dataNext  = '0;
               retryNext = '0;
            end else begin
               gapNext = gapCnt + 1'b1;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state     <= ST_IDLE;
         oGNT      <= '0;
         oDONE     <= '0;
         oERR      <= '0;
         oI2C_GO   <= 1'b0;
         oI2C_DATA <= '0;
         retry     <= '0;
         gapCnt    <= '0;
         rrPtr     <= '0;
         armed     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         toCnt     <= '0;
         toFlag    <= 1'b0;
`endif
      end else begin
         state     <= stateNext;
         oGNT      <= gntNext;
         oDONE     <= doneNext;
         oERR      <= errNext;
         oI2C_GO   <= goNext;
         oI2C_DATA <= dataNext;
         retry     <= retryNext;
         gapCnt    <= gapNext;
         rrPtr     <= ptrNext;
         armed     <= armedNext;
`ifdef I2C_ARB_TIMEOUT_EN
         toCnt     <= toCntNext;
         toFlag    <= toFlagNext;
`endif
      end
   end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - directed scoreboard bench for i2c_cmd_arbiter with a controller BFM
module tb_i2c_cmd_arbiter;
   localparam int N    = 4;
   localparam int MAXR = 2;
   localparam int GAP  = 4;
   localparam int TO   = 100;
   localparam int W    = 24;

   logic           iCLK = 1'b0;
   logic           iRST = 1'b1;
   logic [N-1:0]   iREQ = '0;
   logic [W*N-1:0] iREQ_DATA = '0;
   logic [N-1:0]   oGNT, oDONE, oERR;
   logic           oBUSY, oTIMEOUT, oI2C_GO;
   logic [W-1:0]   oI2C_DATA;
   logic           iI2C_END = 1'b0;
   logic           iI2C_ACK = 1'b0;

   always #5 iCLK = ~iCLK;

   i2c_cmd_arbiter #(
      .N_REQ(N), .MAX_RETRY(MAXR), .GAP_CYC(GAP)
`ifdef I2C_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC(TO)
`endif
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iREQ_DATA(iREQ_DATA),
      .oGNT(oGNT), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY), .oTIMEOUT(oTIMEOUT),
      .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO), .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int           idx;
      bit           isErr;
      logic [W-1:0] data;
   } exp_t;
   exp_t expQ[$];

   // Controller BFM: END with the next queued ACK three cycles after each GO rise.
   bit   mute = 1'b0;
   logic ackQ[$];
   logic goPrev = 1'b0;
   int   cnt = 0, goRises = 0, lowRun = 0, highRun = 0, lastHigh = 0;
   int   lowRuns[$];

   always @(negedge iCLK) begin
      if (iRST) begin
         cnt = 0; iI2C_END = 1'b0; iI2C_ACK = 1'b0; goPrev = 1'b0; lowRun = 0; highRun = 0;
      end else begin
         iI2C_END = 1'b0;
         if (oI2C_GO && !goPrev) begin
            goRises++;
            lowRuns.push_back(lowRun);
            if (!mute) cnt = 3;
         end
         if (!oI2C_GO && goPrev) lastHigh = highRun;
         highRun = oI2C_GO ? highRun + 1 : 0;
         lowRun  = oI2C_GO ? 0 : lowRun + 1;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               iI2C_END = 1'b1;
               iI2C_ACK = (ackQ.size() > 0) ? ackQ.pop_front() : 1'b0;
            end
         end
         goPrev = oI2C_GO;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, " gnt"},  32'(oGNT), 0);
      check({tag, " done"}, 32'(oDONE), 0);
      check({tag, " err"},  32'(oERR), 0);
      check({tag, " busy"}, 32'(oBUSY), 0);
      check({tag, " tmo"},  32'(oTIMEOUT), 0);
      check({tag, " data"}, 32'(oI2C_DATA), 0);
      check({tag, " go"},   32'(oI2C_GO), 0);
   endtask

   task automatic pushExp(input int idx, input bit isErr, input logic [W-1:0] data);
      exp_t e;
      e.idx = idx; e.isErr = isErr; e.data = data;
      expQ.push_back(e);
   endtask

   // Waits for a DONE/ERR pulse and scores it against the head of the expectation queue.
   task automatic serveOne(input string tag, input int maxCyc, input bit dropReq);
      bit got = 1'b0;
      int idx = -1;
      bit isErr = 1'b0;
      logic [W-1:0] data = '0;
      logic [N-1:0] gntAt = '0;
      exp_t e;
      for (int c = 0; c < maxCyc && !got; c++) begin
         @(negedge iCLK);
         if ((oDONE | oERR) != '0) begin
            got = 1'b1;
            isErr = (oERR != '0);
            data = oI2C_DATA;
            gntAt = oGNT;
            for (int k = 0; k < N; k++) if (oDONE[k] | oERR[k]) idx = k;
            if (dropReq) iREQ = iREQ & ~(oDONE | oERR);
         end
      end
      check({tag, " pulse seen"}, 32'(got), 1);
      if (expQ.size() == 0) begin
         check({tag, " scoreboard empty"}, 0, 1);
      end else begin
         e = expQ.pop_front();
         check({tag, " idx"},  32'(idx), 32'(e.idx));
         check({tag, " kind"}, 32'(isErr), 32'(e.isErr));
         check({tag, " data"}, 32'(data), 32'(e.data));
         check({tag, " gnt at pulse"}, 32'(gntAt), 0);
      end
   endtask

   task automatic waitIdle(input string tag);
      bit idle = 1'b0;
      for (int c = 0; c < 60 && !idle; c++) begin
         @(negedge iCLK);
         idle = !oBUSY;
      end
      check({tag, " idle"}, 32'(idle), 1);
   endtask

   task automatic doReset();
      iRST = 1'b1;
      iREQ = '0;
      repeat (2) @(negedge iCLK);
      iRST = 1'b0;
   endtask

   logic [W-1:0] reqData[N];
   int base, lrBase, busyCnt, extraPulse, goSeen, minLow, lows;
   bit seen;

   initial begin
      for (int k = 0; k < N; k++) reqData[k] = 24'h500000 + 24'(k * 24'h010203);
      reqData[1] = 24'h340C00;
      reqData[2] = 24'h1A2B3C;
      for (int k = 0; k < N; k++) iREQ_DATA[W*k +: W] = reqData[k];

      repeat (2) @(negedge iCLK);
      checkResetOutputs("reset");
      iRST = 1'b0;

      // Single request
      base = goRises;
      pushExp(1, 1'b0, 24'h340C00);
      iREQ = 4'b0010;
      repeat (2) @(negedge iCLK);
      check("single gnt", 32'(oGNT), 32'h2);
      check("single data", 32'(oI2C_DATA), 32'h340C00);
      check("single go", 32'(oI2C_GO), 1);
      check("single busy", 32'(oBUSY), 1);
      serveOne("single", 40, 1'b1);
      busyCnt = 0; extraPulse = 0; goSeen = 0; seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge iCLK);
         if (!oBUSY) seen = 1'b1;
         else begin
            busyCnt++;
            if ((oDONE | oERR) != '0) extraPulse++;
            if (oI2C_GO) goSeen++;
         end
      end
      check("single release cycles", 32'(busyCnt + 1), GAP);
      check("single extra pulse", 32'(extraPulse), 0);
      check("single go in release", 32'(goSeen), 0);
      check("single go rises", 32'(goRises - base), 1);

      // Round-robin fairness from reset
      doReset();
      for (int r = 0; r < 5; r++) pushExp(r % N, 1'b0, reqData[r % N]);
      iREQ = 4'b1111;
      for (int r = 0; r < 5; r++) serveOne($sformatf("rr%0d", r), 60, 1'b0);
      iREQ = '0;
      waitIdle("rr");

      // NACK recovery
      base = goRises; lrBase = lowRuns.size();
      ackQ.push_back(1'b1); ackQ.push_back(1'b1); ackQ.push_back(1'b0);
      pushExp(2, 1'b0, reqData[2]);
      iREQ = 4'b0100;
      serveOne("nack ok", 150, 1'b1);
      waitIdle("nack ok");
      check("nack ok go rises", 32'(goRises - base), 3);
      minLow = 1000;
      for (int i = lrBase + 1; i < lowRuns.size(); i++)
         if (lowRuns[i] < minLow) minLow = lowRuns[i];
      check("nack ok gap >= GAP", 32'(minLow >= GAP && minLow < 1000), 1);

      // NACK exhaustion
      base = goRises;
      ackQ.push_back(1'b1); ackQ.push_back(1'b1); ackQ.push_back(1'b1);
      pushExp(3, 1'b1, reqData[3]);
      iREQ = 4'b1000;
      serveOne("nack exhaust", 150, 1'b1);
      waitIdle("nack exhaust");
      check("nack exhaust go rises", 32'(goRises - base), 3);

      // Reset in the middle of WAIT
      mute = 1'b1;
      iREQ = 4'b0010;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge iCLK);
         seen = oI2C_GO;
      end
      check("rst mid go high", 32'(seen), 1);
      @(negedge iCLK);
      #1 iRST = 1'b1;
      #1 checkResetOutputs("rst async");
      @(negedge iCLK);
      checkResetOutputs("rst edge");
      iREQ = 4'b0011;
      mute = 1'b0;
      iRST = 1'b0;
      pushExp(0, 1'b0, reqData[0]);
      pushExp(1, 1'b0, reqData[1]);
      serveOne("rst resume0", 40, 1'b1);
      serveOne("rst resume1", 60, 1'b1);
      waitIdle("rst resume");

      // Watchdog
      mute = 1'b1;
      iREQ = 4'b0001;
`ifdef I2C_ARB_TIMEOUT_EN
      pushExp(0, 1'b1, reqData[0]);
      serveOne("timeout", 250, 1'b1);
      check("timeout go high cycles", 32'(lastHigh), TO);
      check("timeout flag", 32'(oTIMEOUT), 1);
      waitIdle("timeout");
      check("timeout flag sticky", 32'(oTIMEOUT), 1);
`else
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge iCLK);
         seen = oI2C_GO;
      end
      check("no watchdog go high", 32'(seen), 1);
      lows = 0; extraPulse = 0;
      for (int c = 0; c < TO + 50; c++) begin
         @(negedge iCLK);
         if (!oI2C_GO) lows++;
         if ((oDONE | oERR) != '0) extraPulse++;
      end
      check("no watchdog go dropped", 32'(lows), 0);
      check("no watchdog pulse", 32'(extraPulse), 0);
      check("no watchdog flag", 32'(oTIMEOUT), 0);
`endif
      mute = 1'b0;
      doReset();
      checkResetOutputs("final reset");
      check("scoreboard drained", 32'(expQ.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish (errors=%0d checks=%0d)", errors, checks);
      $fatal(1);
   end
endmodule
